dmem_refill: RTL and testbench
==============================

Name: dmem_refill

Overview:
Refill engine directly downstream of the L1 data cache.
- Accepts a cache-line fetch request (block address, level request), issues one burst on the narrower external memory bus, and assembles BEATS bus words into a full line.
- Returns the line to the cache with a single-cycle data-valid pulse.
- Registers and forwards external snoop invalidations to the cache; an invalidation that hits an in-flight fetch forces a refetch.

Parameters:
LINE_W, 256, cache line width in bits (equals DMEM_LINE)
BLK_W, 59, block address width in bits (equals DMEM_BLK_LEN; 64 - log2(LINE_W/8))
BUS_W, 64, external bus data width in bits; BEATS = LINE_W/BUS_W (must be a power of 2, ≥2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
b_addr_d  in  BLK_W  block address from cache (combinational on cache side)
b_rd_d  in  1  fetch request level; held high by cache until b_dv_d
b_rdata_d  out  LINE_W  assembled line, valid when b_dv_d=1
b_dv_d  out  1  line-valid pulse, exactly one cycle per completed request
b_inv_addr_d  out  BLK_W  invalidate block address to cache
inv  out  1  invalidate pulse to cache
m_addr  out  64  external bus byte address = {block, zeros}
m_req  out  1  external address-phase valid
m_gnt  in  1  external address-phase ready
m_rdata  in  BUS_W  external read beat
m_rvalid  in  1  external beat valid (beats in ascending order, no ready)
snp_addr  in  BLK_W  external snoop block address
snp_inv  in  1  external snoop invalidate strobe

Behaviour:
- Reset: state IDLE; m_req=0, m_addr=0, b_dv_d=0, b_rdata_d=0, inv=0, b_inv_addr_d=0; beat counter 0; stale flag 0. Reset mid-burst returns to IDLE at once. The bus shares rst_n; stray m_rvalid beats seen in IDLE are ignored.
- States:
  - IDLE: if b_rd_d=1, latch b_addr_d into fa, clear stale, go to ADDR.
  - ADDR: m_req=1, m_addr={fa, log2(LINE_W/8) zeros}. On m_req&&m_gnt, go to DATA with counter=0. m_addr and m_req stay stable until the handshake.
  - DATA: each m_rvalid writes m_rdata into line[cnt*BUS_W +: BUS_W] and increments cnt. On the beat with cnt=BEATS-1, choose the next state:
    - stale=1, or (b_rd_d=1 and b_addr_d!=fa): relatch fa<=b_addr_d, clear stale, go to ADDR (refetch).
    - b_rd_d=0: abort; go to IDLE with no b_dv_d. The burst always completes on the bus and is never truncated.
    - otherwise: go to RESP.
  - RESP: b_dv_d=1 for one cycle; b_rdata_d holds the full line (registered, stable from RESP until the next DATA). Go to HOLD.
  - HOLD: one cycle that ignores b_rd_d, covering the cache's combinational request release. Go to IDLE.
- Latency: with m_gnt already high and back-to-back beats, b_rd_d rises in cycle 0 → m_req in cycle 1 → beats in cycles 2..BEATS+1 → b_dv_d in cycle BEATS+2 (6 for the defaults). The earliest first beat is the cycle after the address handshake.
- Snoop forwarding: every cycle, inv<=snp_inv and b_inv_addr_d<=snp_addr (1-cycle latency, pass-through in all states). If snp_inv=1 and snp_addr==fa while in ADDR or DATA, set stale.
  - Snoop on the same cycle as the last beat counts as stale.
  - Snoop during RESP/HOLD does not cancel delivery. The forwarded inv reaches the cache after the fill, so the cache invalidates the freshly filled line.
- Back-to-back requests: a new b_rd_d is accepted no earlier than the cycle after HOLD.
- Widths: cnt is log2(BEATS) bits and wraps to 0 after the last beat.

Decomposition:
- Shared package holds LINE_W/BLK_W/BUS_W defaults (mirroring the DMEM_* config macros), BEATS, offset width log2(LINE_W/8), and the state encoding (IDLE=0, ADDR=1, DATA=2, RESP=3, HOLD=4; 3 bits).
- One natural sub-module, dmem_line_asm: beat counter plus line register with write-enable per beat slot and a last-beat flag.

Test Plan:
- Basic fill (m_gnt=1, beats 0x11..,0x22..,0x33..,0x44..) with fa=0x123 → m_addr=0x2460 in cycle 1; b_dv_d single pulse in cycle 6; b_rdata_d={0x44..,0x33..,0x22..,0x11..}.
- m_gnt held low for 3 cycles, then beats with a 2-cycle gap between each → m_addr/m_req stable while waiting; b_dv_d exactly one cycle after the 4th beat; line correct.
- Snoop snp_addr=fa during beat 2 → inv pulse one cycle later with b_inv_addr_d=fa; a second m_req to the same address after beat 4; b_dv_d only after the second burst.
- b_rd_d dropped after beat 1 → remaining 3 beats consumed; no b_dv_d; IDLE; a new request is then serviced normally.
- rst_n low during DATA → all outputs 0 the next cycle; leftover beats ignored; the next request fills correctly.
- b_rd_d held high across RESP and HOLD → exactly one b_dv_d; the new request is accepted only in IDLE.

Source files
------------

// File: rtl/dmem_refill_pkg.sv
// dmem_refill_pkg: line/bus geometry defaults and FSM encoding shared by the refill engine
package dmem_refill_pkg;
   localparam int DMEM_LINE    = 256;
   localparam int DMEM_BLK_LEN = 59;
   localparam int DMEM_BUS     = 64;
   localparam int DMEM_BEATS   = DMEM_LINE / DMEM_BUS;
   localparam int DMEM_OFF_W   = $clog2(DMEM_LINE / 8);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_RESP = 3'd3,
      S_HOLD = 3'd4
   } state_e;
endpackage

// File: rtl/dmem_line_asm.sv
// dmem_line_asm: beat counter and line register assembling ascending bus beats into one cache line
module dmem_line_asm
   import dmem_refill_pkg::*;
#(
   parameter int LINE_W = DMEM_LINE,
   parameter int BUS_W  = DMEM_BUS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [BUS_W-1:0]  wdata_i,
   output logic              last_o,
   output logic [LINE_W-1:0] line_o
);
   localparam int BEATS = LINE_W / BUS_W;
   localparam int CNT_W = $clog2(BEATS);
   logic [CNT_W-1:0] cnt_q;
   assign last_o = cnt_q == CNT_W'(BEATS - 1);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         line_o <= '0;
      end else if (we_i) begin
         cnt_q <= cnt_q + CNT_W'(1);
         for (int i = 0; i < BEATS; i++)
            if (cnt_q == CNT_W'(i)) line_o[i*BUS_W +: BUS_W] <= wdata_i;
      end
   end
endmodule

// File: rtl/dmem_refill.sv
// dmem_refill: L1D line refill engine; one burst per fetch, snoop forwarding with stale-refetch
module dmem_refill
   import dmem_refill_pkg::*;
#(
   parameter int LINE_W = DMEM_LINE,
   parameter int BLK_W  = DMEM_BLK_LEN,
   parameter int BUS_W  = DMEM_BUS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BLK_W-1:0]  b_addr_d,
   input  logic              b_rd_d,
   output logic [LINE_W-1:0] b_rdata_d,
   output logic              b_dv_d,
   output logic [BLK_W-1:0]  b_inv_addr_d,
   output logic              inv,
   output logic [63:0]       m_addr,
   output logic              m_req,
   input  logic              m_gnt,
   input  logic [BUS_W-1:0]  m_rdata,
   input  logic              m_rvalid,
   input  logic [BLK_W-1:0]  snp_addr,
   input  logic              snp_inv
);
   localparam int OFF_W = $clog2(LINE_W / 8);
   state_e           state_q;
   logic [BLK_W-1:0] fa_q;
   logic [BLK_W-1:0] inv_addr_q;
   logic [63:0]      m_addr_q;
   logic             stale_q;
   logic             m_req_q;
   logic             b_dv_q;
   logic             inv_q;
   logic             beat;
   logic             last;
   logic             snp_hit;
   logic             refetch;
   assign beat    = state_q == S_DATA && m_rvalid;
   assign snp_hit = snp_inv && snp_addr == fa_q && (state_q == S_ADDR || state_q == S_DATA);
   // a snoop landing on the final beat still poisons the line just assembled
   assign refetch = stale_q || snp_hit || (b_rd_d && b_addr_d != fa_q);
   dmem_line_asm #(.LINE_W(LINE_W), .BUS_W(BUS_W)) u_asm (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (beat),
      .wdata_i (m_rdata),
      .last_o  (last),
      .line_o  (b_rdata_d)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         fa_q       <= '0;
         stale_q    <= 1'b0;
         m_req_q    <= 1'b0;
         m_addr_q   <= '0;
         b_dv_q     <= 1'b0;
         inv_q      <= 1'b0;
         inv_addr_q <= '0;
      end else begin
         inv_q      <= snp_inv;
         inv_addr_q <= snp_addr;
         b_dv_q     <= 1'b0;
         stale_q    <= stale_q | snp_hit;
         case (state_q)
            S_IDLE: if (b_rd_d) begin
               fa_q     <= b_addr_d;
               stale_q  <= 1'b0;
               m_req_q  <= 1'b1;
               m_addr_q <= 64'({b_addr_d, {OFF_W{1'b0}}});
               state_q  <= S_ADDR;
            end
            S_ADDR: if (m_req_q && m_gnt) begin
               m_req_q <= 1'b0;
               state_q <= S_DATA;
            end
            S_DATA: if (beat && last) begin
               if (refetch) begin
                  fa_q     <= b_addr_d;
                  stale_q  <= 1'b0;
                  m_req_q  <= 1'b1;
                  m_addr_q <= 64'({b_addr_d, {OFF_W{1'b0}}});
                  state_q  <= S_ADDR;
               end else if (!b_rd_d) begin
                  state_q <= S_IDLE;
               end else begin
                  b_dv_q  <= 1'b1;
                  state_q <= S_RESP;
               end
            end
            S_RESP: state_q <= S_HOLD;
            default: state_q <= S_IDLE;
         endcase
      end
   end
   assign b_dv_d       = b_dv_q;
   assign inv          = inv_q;
   assign b_inv_addr_d = inv_addr_q;
   assign m_req        = m_req_q;
   assign m_addr       = m_addr_q;
endmodule

// File: tb/tb_dmem_refill.sv
// tb_dmem_refill: table-driven fills with a scoreboard of expected lines plus hand-written corner sequences
module tb_dmem_refill;
   import dmem_refill_pkg::*;
   localparam int LINE_W = DMEM_LINE;
   localparam int BLK_W  = DMEM_BLK_LEN;
   localparam int BUS_W  = DMEM_BUS;
   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [BLK_W-1:0]  b_addr_d = '0;
   logic              b_rd_d = 1'b0;
   logic [LINE_W-1:0] b_rdata_d;
   logic              b_dv_d;
   logic [BLK_W-1:0]  b_inv_addr_d;
   logic              inv;
   logic [63:0]       m_addr;
   logic              m_req;
   logic              m_gnt = 1'b0;
   logic [BUS_W-1:0]  m_rdata = '0;
   logic              m_rvalid = 1'b0;
   logic [BLK_W-1:0]  snp_addr = '0;
   logic              snp_inv = 1'b0;
   always #5 clk = ~clk;
   dmem_refill dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .b_addr_d     (b_addr_d),
      .b_rd_d       (b_rd_d),
      .b_rdata_d    (b_rdata_d),
      .b_dv_d       (b_dv_d),
      .b_inv_addr_d (b_inv_addr_d),
      .inv          (inv),
      .m_addr       (m_addr),
      .m_req        (m_req),
      .m_gnt        (m_gnt),
      .m_rdata      (m_rdata),
      .m_rvalid     (m_rvalid),
      .snp_addr     (snp_addr),
      .snp_inv      (snp_inv)
   );
   int checks = 0;
   int failures = 0;
   int n_dv = 0;
   logic dv_prev = 1'b0;
   logic [LINE_W-1:0] sb[$];
   int gd_cfg = 0;
   int gap_cfg = 0;
   logic [BUS_W-1:0] beat_val[DMEM_BEATS];
   int wait_n = 0;
   int left = 0;
   int gap_n = 0;
   logic hs = 1'b0;
   typedef struct {
      logic [BLK_W-1:0] blk;
      int               gd;
      int               gap;
      int               snp_cyc;
      logic             snp_match;
      int               lat;
      int               nreq;
   } vec_t;
   vec_t tbl[8];
   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic prep(input int salt, output logic [LINE_W-1:0] line);
      for (int k = 0; k < DMEM_BEATS; k++) begin
         beat_val[k] = {16{4'(k + 1)}} ^ (64'(salt) << 40);
         line[k*BUS_W +: BUS_W] = beat_val[k];
      end
   endtask
   // memory-side responder: grant after gd_cfg waiting cycles, beats spaced by gap_cfg idle cycles
   initial begin
      forever begin
         cyc();
         m_rvalid = 1'b0;
         if (hs) begin
            left  = DMEM_BEATS;
            gap_n = 0;
         end
         if (left > 0) begin
            if (gap_n == 0) begin
               m_rvalid = 1'b1;
               m_rdata  = beat_val[DMEM_BEATS-left];
               left--;
               gap_n = gap_cfg;
            end else gap_n--;
         end
         m_gnt  = m_req && wait_n >= gd_cfg;
         wait_n = m_req ? wait_n + 1 : 0;
         hs     = m_req && m_gnt;
      end
   end
   always @(negedge clk) begin
      if (rst_n && b_dv_d) begin
         n_dv++;
         chk("dv_single_cycle", dv_prev, 1'b0);
         chk("dv_expected", sb.size() != 0, 1'b1);
         if (sb.size() != 0) chk("line", b_rdata_d, sb.pop_front());
      end
      dv_prev = rst_n && b_dv_d;
   end
   task automatic fill(input int i);
      vec_t v;
      int dv_cyc, nreq, bad_addr, bad_inv;
      logic req_prev;
      logic [LINE_W-1:0] exp_line;
      logic [BLK_W-1:0] saddr;
      v = tbl[i];
      gd_cfg  = v.gd;
      gap_cfg = v.gap;
      prep(i, exp_line);
      saddr = v.snp_match ? v.blk : ~v.blk;
      sb.push_back(exp_line);
      dv_cyc = -1; nreq = 0; bad_addr = 0; bad_inv = 0; req_prev = 1'b0;
      cyc();
      b_addr_d = v.blk;
      b_rd_d   = 1'b1;
      snp_addr = saddr;
      snp_inv  = v.snp_cyc == 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (m_req && !req_prev) nreq++;
         if (m_req && m_addr !== {v.blk, {DMEM_OFF_W{1'b0}}}) bad_addr++;
         if (c == 1 && !m_req) bad_addr++;
         if (inv !== (v.snp_cyc >= 0 && c == v.snp_cyc + 1) || (inv && b_inv_addr_d !== saddr)) bad_inv++;
         req_prev = m_req;
         if (b_dv_d && dv_cyc < 0) dv_cyc = c;
         if (dv_cyc >= 0 && c >= dv_cyc + 2) break;
         cyc();
         snp_inv = c + 1 == v.snp_cyc;
         if (dv_cyc >= 0) b_rd_d = 1'b0;
      end
      b_rd_d  = 1'b0;
      snp_inv = 1'b0;
      chk($sformatf("v%0d_latency", i), dv_cyc, v.lat);
      chk($sformatf("v%0d_bursts", i), nreq, v.nreq);
      chk($sformatf("v%0d_maddr_bad", i), bad_addr, 0);
      chk($sformatf("v%0d_inv_bad", i), bad_inv, 0);
      repeat (3) cyc();
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end
   initial begin
      int n0, nreq, r2;
      logic req_prev;
      logic [LINE_W-1:0] tmp;
      tbl[0] = '{59'h123,        0, 0, -1, 1'b1,  6, 1};
      tbl[1] = '{59'h0ABCDEF,    3, 2, -1, 1'b1, 15, 1};
      tbl[2] = '{59'h555,        0, 0,  3, 1'b1, 11, 2};
      tbl[3] = '{59'h555,        0, 0,  5, 1'b1, 11, 2};
      tbl[4] = '{59'h777,        0, 0,  6, 1'b1,  6, 1};
      tbl[5] = '{59'h777,        0, 0,  3, 1'b0,  6, 1};
      tbl[6] = '{{BLK_W{1'b1}},  1, 1, -1, 1'b1, 10, 1};
      tbl[7] = '{59'h1F0F0F0F,   1, 1,  1, 1'b1, 19, 2};
      prep(0, tmp);
      repeat (3) cyc();
      @(negedge clk);
      chk("reset_line", b_rdata_d, '0);
      chk("reset_ctl", {m_req, b_dv_d, inv, m_addr, b_inv_addr_d}, '0);
      cyc();
      rst_n = 1'b1;
      repeat (2) cyc();
      for (int i = 0; i < 8; i++) fill(i);
      // abort: request dropped after the first beat, burst still drains, no delivery
      gd_cfg = 0; gap_cfg = 0;
      prep(20, tmp);
      n0 = n_dv; nreq = 0; req_prev = 1'b0;
      cyc();
      b_addr_d = 59'h42;
      b_rd_d   = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (m_req && !req_prev) nreq++;
         req_prev = m_req;
         cyc();
         if (c + 1 == 3) b_rd_d = 1'b0;
      end
      chk("abort_no_dv", n_dv - n0, 0);
      chk("abort_bursts", nreq, 1);
      fill(0);
      // reset in the middle of a burst
      prep(21, tmp);
      snp_addr = '0;
      cyc();
      b_addr_d = 59'h99;
      b_rd_d   = 1'b1;
      repeat (3) cyc();
      rst_n = 1'b0;
      cyc();
      rst_n  = 1'b1;
      b_rd_d = 1'b0;
      @(negedge clk);
      chk("midrst_line", b_rdata_d, '0);
      chk("midrst_ctl", {m_req, b_dv_d, inv, m_addr, b_inv_addr_d}, '0);
      repeat (3) cyc();
      @(negedge clk);
      chk("midrst_stray_line", b_rdata_d, '0);
      chk("midrst_idle", {m_req, b_dv_d}, '0);
      repeat (3) cyc();
      fill(1);
      // request held high through RESP and HOLD: second fill starts only from IDLE
      gd_cfg = 0; gap_cfg = 0;
      prep(22, tmp);
      sb.push_back(tmp);
      sb.push_back(tmp);
      n0 = n_dv; nreq = 0; r2 = -1; req_prev = 1'b0;
      cyc();
      b_addr_d = 59'h3C3;
      b_rd_d   = 1'b1;
      for (int c = 0; c < 21; c++) begin
         @(negedge clk);
         if (m_req && !req_prev) begin
            nreq++;
            if (nreq == 2) r2 = c;
         end
         req_prev = m_req;
         if (c == 8) chk("held_one_dv", n_dv - n0, 1);
         cyc();
         if (c + 1 == 15) b_rd_d = 1'b0;
      end
      chk("held_second_req_cycle", r2, 9);
      chk("held_total_dv", n_dv - n0, 2);
      repeat (3) cyc();
      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
